uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters, range 2..8.
REQ-002 Parameter TAG_BASE, default 8'hA0: tag byte base; tag = TAG_BASE | grant id (used only with UART_ARB_TAG_EN).
REQ-003 i_Clock  in  1  sole clock, all logic on rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 i_Req_DV  in  NUM_REQ  per-requester byte valid, held until acknowledged.
REQ-006 i_Req_Byte  in  8*NUM_REQ  requester k byte on bits [8k+7:8k].
REQ-007 o_Req_Ack  out  NUM_REQ  registered one-hot, one-cycle accept pulse.
REQ-008 o_Grant_Id  out  clog2(NUM_REQ)  id of requester currently owning the transmitter.
REQ-009 o_Busy  out  1  high from grant until the granted frame(s) finish.
REQ-010 o_Tx_DV  out  1  start request to the UART transmitter.
REQ-011 o_Tx_Byte  out  8  byte to the UART transmitter, stable while o_Tx_DV is high.
REQ-012 i_Tx_Active  in  1  transmitter active flag (high from the cycle after start acceptance to the end of the stop bit).

Function
REQ-013 States: S_IDLE, S_TAG_SEND, S_TAG_WAIT, S_DATA_SEND, S_DATA_WAIT.
REQ-014 S_IDLE: arbitrate only when i_Tx_Active==0 and some i_Req_DV is high; otherwise stay.
REQ-015 Arbitration is round-robin: search from (last_grant+1) mod NUM_REQ upward, wrapping; first requester with DV high wins.
REQ-016 At the grant edge, latch that requester's byte, update last_grant and o_Grant_Id, and assert o_Req_Ack[id] for exactly the next cycle.
REQ-017 Transition at grant: to S_TAG_SEND if UART_ARB_TAG_EN is defined, else to S_DATA_SEND.
REQ-018 *_SEND: drive o_Tx_DV=1 with the tag or latched byte; hold until i_Tx_Active==1 is sampled, then deassert o_Tx_DV and go to the matching *_WAIT.
REQ-019 S_TAG_WAIT: when i_Tx_Active==0 is sampled, go to S_DATA_SEND.
REQ-020 S_DATA_WAIT: when i_Tx_Active==0 is sampled, go to S_IDLE.
REQ-021 Holding DV across the transmitter's one-cycle cleanup is required; no extra gap counter.
REQ-022 o_Busy=1 in every state except S_IDLE.
REQ-023 Requesters not granted see no ack and keep DV.
REQ-024 A requester deasserting DV before ack forfeits the request with no error.
REQ-025 Earliest re-arbitration is the cycle after the return to S_IDLE; back-to-back frames from the same requester are allowed if it is the only one requesting.
REQ-026 Tag value = TAG_BASE with the low clog2(NUM_REQ) bits ORed with the grant id, truncated to 8 bits.
REQ-027 Illegal state encodings return to S_IDLE with o_Tx_DV=0 the next cycle.

Reset
REQ-028 Reset values: state S_IDLE, o_Tx_DV=0, o_Tx_Byte=0, o_Req_Ack=0, o_Busy=0, o_Grant_Id=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
REQ-029 Reset asserted mid-frame aborts the sequence; no ack is re-issued.
REQ-030 Because the transmitter has no reset, the block does not grant until i_Tx_Active==0 is sampled (covered by REQ-014).

Configuration
REQ-031 Macro UART_ARB_TAG_EN: when defined, each grant sends the tag frame and then the data frame; when undefined, S_TAG_SEND/S_TAG_WAIT and TAG_BASE logic are absent and only the data frame is sent.

Structure
REQ-032 Package uart_arb_pkg holds the state enum, the TAG_BASE default and the state-width constant.
REQ-033 Sub-module rr_arbiter: combinational round-robin picker (req vector, last grant -> winner id, found flag); the FSM lives in uart_tx_arbiter.

Verification
REQ-034 Bench instantiates the real uart_tx with CLKS_PER_BIT=4.
REQ-035 Single request: reset, then DV[2]=1, byte 8'h5A (tag off) -> Ack[2] one cycle after the grant edge, serial 0,0,1,0,1,1,0,1,0,1 LSB-first, 4 clocks per bit, o_Busy falls after the stop bit.
REQ-036 All four requesting continuously, bytes 8'h10..8'h13 -> frame order 10,11,12,13,10, with exactly one ack per frame.
REQ-037 Tag on, DV[3]=1, byte 8'hC3 -> serial frames A3 then C3, a single Ack[3], o_Grant_Id=3 throughout.
REQ-038 Reset asserted in S_DATA_WAIT while the transmitter is active -> o_Tx_DV=0, o_Busy=0, no new grant until i_Tx_Active falls, and requester 0 wins first afterwards.
REQ-039 DV[1] dropped while requester 0 transmits; requesters 0 and 2 held -> next grant is 2, never 1, and o_Tx_DV is never high while i_Tx_Active is high in S_IDLE.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

   localparam int unsigned STATE_W          = 3;
   localparam logic [7:0]  TAG_BASE_DEFAULT = 8'hA0;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE      = 3'd0,
      S_TAG_SEND  = 3'd1,
      S_TAG_WAIT  = 3'd2,
      S_DATA_SEND = 3'd3,
      S_DATA_WAIT = 3'd4
   } t_arb_state;

   // Tag byte announces which requester owns the following data frame.
   function automatic logic [7:0] tag_byte(input logic [7:0] i_base, input logic [2:0] i_id);
      return i_base | {5'b00000, i_id};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester after i_Last,
// wrapping, and reports the first active request.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_Req,
   input  logic [$clog2(NUM_REQ)-1:0] i_Last,
   output logic [$clog2(NUM_REQ)-1:0] o_Winner,
   output logic                       o_Found
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0] w_Idx;

   always_comb begin
      o_Found  = 1'b0;
      o_Winner = '0;
      w_Idx    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_Idx = ID_W'((32'(i_Last) + k) % NUM_REQ);
         if (!o_Found && i_Req[w_Idx]) begin
            o_Found  = 1'b1;
            o_Winner = w_Idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Simple 8N1 UART transmitter with no reset; active flag rises the cycle after a start
// request is accepted and falls at the end of the stop bit, followed by one cleanup cycle.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       i_Clock,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP
   } t_tx_state;

   localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

   t_tx_state   r_State   = TX_IDLE;
   logic [15:0] r_Clk_Cnt = '0;
   logic [2:0]  r_Bit_Idx = '0;
   logic [7:0]  r_Byte    = '0;
   logic        r_Active  = 1'b0;
   logic        r_Done    = 1'b0;

   always_ff @(posedge i_Clock) begin
      r_Done <= 1'b0;
      case (r_State)
         TX_IDLE: begin
            r_Clk_Cnt <= '0;
            r_Bit_Idx <= '0;
            if (i_Tx_DV) begin
               r_Byte   <= i_Tx_Byte;
               r_Active <= 1'b1;
               r_State  <= TX_START;
            end
         end
         TX_START: begin
            if (r_Clk_Cnt == LAST_CLK) begin
               r_Clk_Cnt <= '0;
               r_State   <= TX_DATA;
            end else begin
               r_Clk_Cnt <= r_Clk_Cnt + 16'd1;
            end
         end
         TX_DATA: begin
            if (r_Clk_Cnt == LAST_CLK) begin
               r_Clk_Cnt <= '0;
               r_Bit_Idx <= r_Bit_Idx + 3'd1;
               if (r_Bit_Idx == 3'd7) r_State <= TX_STOP;
            end else begin
               r_Clk_Cnt <= r_Clk_Cnt + 16'd1;
            end
         end
         TX_STOP: begin
            if (r_Clk_Cnt == LAST_CLK) begin
               r_Clk_Cnt <= '0;
               r_Active  <= 1'b0;
               r_Done    <= 1'b1;
               r_State   <= TX_CLEANUP;
            end else begin
               r_Clk_Cnt <= r_Clk_Cnt + 16'd1;
            end
         end
         TX_CLEANUP: r_State <= TX_IDLE;
         default: begin
            r_Active <= 1'b0;
            r_State  <= TX_IDLE;
         end
      endcase
   end

   assign o_Tx_Serial = (r_State == TX_START) ? 1'b0 :
                        (r_State == TX_DATA)  ? r_Byte[r_Bit_Idx] : 1'b1;
   assign o_Tx_Active = r_Active;
   assign o_Tx_Done   = r_Done;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_TAG_EN to precede each data frame with a tag frame naming the requester.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter logic [7:0]  TAG_BASE = TAG_BASE_DEFAULT
) (
   input  logic                       i_Clock,
   input  logic                       i_Reset,
   input  logic [NUM_REQ-1:0]         i_Req_DV,
   input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
   output logic [NUM_REQ-1:0]         o_Req_Ack,
   output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
   output logic                       o_Busy,
   output logic                       o_Tx_DV,
   output logic [7:0]                 o_Tx_Byte,
   input  logic                       i_Tx_Active
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   t_arb_state           r_State, w_Next;
   logic [ID_W-1:0]      r_Last_Grant, r_Grant_Id, w_Winner;
   logic                 w_Found, w_Grant;
   logic [NUM_REQ-1:0]   r_Req_Ack, w_Ack_Onehot;
   logic [7:0]           r_Tx_Byte, w_Req_Sel;
`ifdef UART_ARB_TAG_EN
   logic [7:0]           r_Data_Byte;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .i_Req    (i_Req_DV),
      .i_Last   (r_Last_Grant),
      .o_Winner (w_Winner),
      .o_Found  (w_Found)
   );

   assign w_Req_Sel    = i_Req_Byte[{w_Winner, 3'b000} +: 8];
   assign w_Ack_Onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_Winner;

   // Never start a grant while the transmitter is busy or in an unknown post-power-up frame.
   always_comb begin
      w_Next  = r_State;
      w_Grant = 1'b0;
      case (r_State)
         S_IDLE: begin
            if (!i_Tx_Active && w_Found) begin
               w_Grant = 1'b1;
`ifdef UART_ARB_TAG_EN
               w_Next  = S_TAG_SEND;
`else
               w_Next  = S_DATA_SEND;
`endif
            end
         end
`ifdef UART_ARB_TAG_EN
         S_TAG_SEND:  if (i_Tx_Active)  w_Next = S_TAG_WAIT;
         S_TAG_WAIT:  if (!i_Tx_Active) w_Next = S_DATA_SEND;
`endif
         S_DATA_SEND: if (i_Tx_Active)  w_Next = S_DATA_WAIT;
         S_DATA_WAIT: if (!i_Tx_Active) w_Next = S_IDLE;
         default:                       w_Next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State      <= S_IDLE;
         r_Last_Grant <= ID_W'(NUM_REQ - 1);
         r_Grant_Id   <= '0;
         r_Req_Ack    <= '0;
         r_Tx_Byte    <= '0;
`ifdef UART_ARB_TAG_EN
         r_Data_Byte  <= '0;
`endif
      end else begin
         r_State   <= w_Next;
         r_Req_Ack <= '0;
         if (w_Grant) begin
            r_Req_Ack    <= w_Ack_Onehot;
            r_Last_Grant <= w_Winner;
            r_Grant_Id   <= w_Winner;
`ifdef UART_ARB_TAG_EN
            r_Tx_Byte    <= tag_byte(TAG_BASE, 3'(w_Winner));
            r_Data_Byte  <= w_Req_Sel;
`else
            r_Tx_Byte    <= w_Req_Sel;
`endif
         end
`ifdef UART_ARB_TAG_EN
         if (r_State == S_TAG_WAIT && !i_Tx_Active) r_Tx_Byte <= r_Data_Byte;
`endif
      end
   end

   assign o_Req_Ack  = r_Req_Ack;
   assign o_Grant_Id = r_Grant_Id;
   assign o_Tx_Byte  = r_Tx_Byte;
   assign o_Busy     = (r_State != S_IDLE);
`ifdef UART_ARB_TAG_EN
   assign o_Tx_DV    = (r_State == S_DATA_SEND) || (r_State == S_TAG_SEND);
`else
   assign o_Tx_DV    = (r_State == S_DATA_SEND);
`endif

endmodule
